// File: rtl/wm8731_reg_sequencer.sv
// Purpose: sends the WM8731 bring-up table to an I2C master, then rewrites R2/R4 on volume/select changes.
// Latency: first i2c_go on the 3rd clock after reset; 16 idle clocks between words. Optional volume stepping: WM8731_VOLUME_CTRL_EN.
// Backpressure: one word in flight; holds i2c_go/i2c_data until i2c_end, retries on NACK or timeout.
module wm8731_reg_sequencer #(
    parameter logic [7:0] DEV_ADDR       = 8'h34,
    parameter logic [6:0] VOL_DEFAULT    = 7'h79,
    parameter logic [6:0] VOL_MIN        = 7'h30,
    parameter logic [6:0] VOL_MAX        = 7'h7F,
    parameter int         VOL_STEP       = 4,
    parameter int         MAX_RETRY      = 3,
    parameter int         SETTLE_CYCLES  = 16,
    parameter int         TIMEOUT_CYCLES = 65535
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        volume_key,
    input  logic [2:0]  sound_select,
    input  logic        i2c_end,
    input  logic        i2c_nack,
    output logic        i2c_go,
    output logic [23:0] i2c_data,
    output logic        config_done,
    output logic        config_error,
    output logic [6:0]  volume,
    output logic [3:0]  reg_index
);

    localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam int SW = $clog2(SETTLE_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [3:0] LAST_INDEX = 4'd9;
    localparam logic [3:0] VOL_INDEX  = 4'd4;
    localparam logic [3:0] SEL_INDEX  = 4'd5;

    typedef enum logic [3:0] {
        S_IDLE, S_LOAD, S_START, S_WAIT_END, S_CHECK,
        S_RELEASE, S_SETTLE, S_DONE, S_ERROR
    } state_t;

    state_t          state, state_next;
    logic [RW-1:0]   retry;
    logic [SW-1:0]   settle_cnt;
    logic [TW-1:0]   to_cnt;
    logic            nack_q;
    logic [2:0]      ss_meta, ss_sync, ss_lat;
    logic            ss_valid;
    logic            pend_vol, pend_sel;
    logic            key_edge;
    logic            sel_mismatch;
    logic            timeout, settle_done;
    logic [15:0]     tbl_word;

    assign timeout      = (to_cnt == TW'(TIMEOUT_CYCLES - 1));
    assign settle_done  = (settle_cnt == SW'(SETTLE_CYCLES - 1));
    assign sel_mismatch = ss_valid && (ss_sync != ss_lat);

`ifdef WM8731_VOLUME_CTRL_EN
    logic [2:0] key_sync;
    logic [7:0] vol_sum;

    assign key_edge = key_sync[1] & ~key_sync[2];
    assign vol_sum  = {1'b0, volume} + 8'(VOL_STEP);

    always_ff @(posedge clock) begin
        if (reset) begin
            key_sync <= 3'b000;
            volume   <= VOL_DEFAULT;
        end else begin
            key_sync <= {key_sync[1:0], volume_key};
            if (key_edge)
                volume <= (vol_sum > {1'b0, VOL_MAX}) ? VOL_MIN : vol_sum[6:0];
        end
    end
`else
    logic unused_key;
    assign unused_key = volume_key;
    assign key_edge   = 1'b0;
    assign volume     = VOL_DEFAULT;
`endif

    // {reg[6:0], data[8:0]} for the entry at reg_index
    always_comb begin
        tbl_word = 16'h0000;
        case (reg_index)
            4'd0: tbl_word = {7'd15, 9'h000};
            4'd1: tbl_word = {7'd6,  9'h000};
            4'd2: tbl_word = {7'd0,  9'h017};
            4'd3: tbl_word = {7'd1,  9'h017};
            4'd4: tbl_word = {7'd2,  1'b1, 1'b0, volume};
            4'd5: tbl_word = {7'd4,  1'b0, 4'b0001, ss_sync[1], ss_sync[0], ss_sync[2], 1'b0};
            4'd6: tbl_word = {7'd5,  9'h000};
            4'd7: tbl_word = {7'd7,  9'h042};
            4'd8: tbl_word = {7'd8,  9'h000};
            4'd9: tbl_word = {7'd9,  9'h001};
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) state <= S_IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:     state_next = S_LOAD;
            S_LOAD:     state_next = S_START;
            S_START:    state_next = S_WAIT_END;
            S_WAIT_END: if (i2c_end || timeout) state_next = S_CHECK;
            S_CHECK: begin
                if (nack_q && retry == RW'(MAX_RETRY)) state_next = S_ERROR;
                else                                   state_next = S_RELEASE;
            end
            S_RELEASE:  if (!i2c_end) state_next = S_SETTLE;
            // A pending retry resends even after init has completed
            S_SETTLE: begin
                if (settle_done)
                    state_next = (retry != '0 || !config_done) ? S_LOAD : S_DONE;
            end
            S_DONE:     if (pend_vol || pend_sel) state_next = S_LOAD;
            S_ERROR:    state_next = S_ERROR;
            default:    state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            i2c_go       <= 1'b0;
            i2c_data     <= 24'h000000;
            config_done  <= 1'b0;
            config_error <= 1'b0;
            reg_index    <= 4'd0;
            retry        <= '0;
            settle_cnt   <= '0;
            to_cnt       <= '0;
            nack_q       <= 1'b0;
            ss_meta      <= 3'b000;
            ss_sync      <= 3'b000;
            ss_lat       <= 3'b000;
            ss_valid     <= 1'b0;
            pend_vol     <= 1'b0;
            pend_sel     <= 1'b0;
        end else begin
            ss_meta <= sound_select;
            ss_sync <= ss_meta;

            case (state)
                S_LOAD: begin
                    i2c_data <= {DEV_ADDR, tbl_word};
                    if (reg_index == SEL_INDEX) begin
                        ss_lat   <= ss_sync;
                        ss_valid <= 1'b1;
                    end
                end
                S_START: begin
                    i2c_go <= 1'b1;
                    to_cnt <= '0;
                end
                S_WAIT_END: begin
                    if (i2c_end || timeout) begin
                        i2c_go <= 1'b0;
                        nack_q <= !i2c_end || i2c_nack;
                    end else begin
                        to_cnt <= to_cnt + TW'(1);
                    end
                end
                S_CHECK: begin
                    settle_cnt <= '0;
                    if (nack_q) begin
                        if (retry != RW'(MAX_RETRY)) begin
                            retry <= retry + RW'(1);
                        end else begin
                            config_error <= 1'b1;
                            config_done  <= 1'b0;
                        end
                    end else begin
                        retry <= '0;
                        if (!config_done) begin
                            if (reg_index == LAST_INDEX) config_done <= 1'b1;
                            else                         reg_index   <= reg_index + 4'd1;
                        end
                    end
                end
                S_RELEASE: settle_cnt <= '0;
                S_SETTLE:  settle_cnt <= settle_cnt + SW'(1);
                S_DONE: begin
                    if (pend_vol)      reg_index <= VOL_INDEX;
                    else if (pend_sel) reg_index <= SEL_INDEX;
                end
                default: ;
            endcase

            // A new edge wins over the clear so a late press still gets its own rewrite
            if (key_edge)
                pend_vol <= 1'b1;
            else if (state == S_LOAD && config_done && reg_index == VOL_INDEX)
                pend_vol <= 1'b0;

            if (state == S_LOAD && reg_index == SEL_INDEX)
                pend_sel <= 1'b0;
            else if (sel_mismatch)
                pend_sel <= 1'b1;
        end
    end

endmodule
